target_generator: RTL and testbench



---
 rtl/target_generator_pkg.sv | 16 +
 rtl/target_generator_if.sv | 25 ++
 rtl/target_generator_lfsr_8.sv | 21 ++
 rtl/target_generator.sv | 120 ++++++++++++
 tb/tb_target_generator.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/target_generator_pkg.sv
// Shared widths, LFSR feedback taps and FSM state encoding for the
// target generator game block.
package target_generator_pkg;
  localparam int NUM_W  = 4;
  localparam int LFSR_W = 8;
  // Feedback from b7, b5, b4, b3 (x^8 + x^6 + x^5 + x^4 + 1, maximal length)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESULT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;
endpackage

// File: rtl/target_generator_if.sv
// Player/comparator handshake of the target generator; the game block
// is the slave, the player side (or bench) is the master.
interface target_generator_if;
  import target_generator_pkg::*;

  logic             start;
  logic             submit;
  logic             match;
  logic [0:NUM_W-1] target;
  logic             round_active;
  logic             hit;
  logic             miss;
  logic [NUM_W-1:0] score;
  logic             game_over;

  modport master (
    output start, submit, match,
    input  target, round_active, hit, miss, score, game_over
  );

  modport slave (
    input  start, submit, match,
    output target, round_active, hit, miss, score, game_over
  );
endinterface

// File: rtl/target_generator_lfsr_8.sv
// Free-running 8-bit Fibonacci LFSR: shifts left every cycle, the new
// bit 0 is the parity of the tapped bits.
module lfsr_8
  import target_generator_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      value <= {value[LFSR_W-2:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/target_generator.sv
// Number-guessing round controller: draws a target per round from the
// LFSR, times out unanswered rounds and keeps a saturating hit score.
module target_generator
  import target_generator_pkg::*;
#(
  parameter int              ROUNDS         = 8,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter logic [LFSR_W-1:0] SEED         = 8'hA5
) (
  input logic               clk,
  input logic               rst_n,
  target_generator_if.slave bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD   = ST_LOAD;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_RESULT = ST_RESULT;
  localparam logic [2:0] S_DONE   = ST_DONE;

  localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_W-1:0] ONE       = NUM_W'(1);
  localparam logic [NUM_W-1:0] SCORE_MAX = '1;
  localparam logic [NUM_W-1:0] LAST_RND  = NUM_W'(ROUNDS - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [NUM_W-1:0]  r_target;
  logic [NUM_W-1:0]  r_score;
  logic [NUM_W-1:0]  r_round;
  logic [TMR_W-1:0]  r_timer;
  logic              r_hit;
  logic              r_miss;
  logic [LFSR_W-1:0] w_lfsr;
  logic [NUM_W-1:0]  w_nib;
  logic [NUM_W-1:0]  w_load_val;
  logic              w_timeout;
  logic              w_unused_lfsr;

  function automatic logic [NUM_W-1:0] sat_inc(input logic [NUM_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + ONE;
  endfunction

  lfsr_8 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (w_lfsr)
  );

  // Never draw the same target twice in a row: bump by one (mod 16).
  assign w_nib         = w_lfsr[NUM_W-1:0];
  assign w_load_val    = (w_nib == r_target) ? w_nib + ONE : w_nib;
  assign w_timeout     = (r_timer == TMR_LAST);
  assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:NUM_W];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (bus.start) w_state_nxt = S_LOAD;
      S_LOAD:         w_state_nxt = S_WAIT;
      S_WAIT:         if (bus.submit || w_timeout) w_state_nxt = S_RESULT;
      S_RESULT:       w_state_nxt = (r_round == LAST_RND) ? S_DONE : S_LOAD;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_score  <= '0;
      r_round  <= '0;
      r_timer  <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_score <= '0;
            r_round <= '0;
          end
        end
        S_LOAD: begin
          r_target <= w_load_val;
          r_timer  <= '0;
        end
        S_WAIT: begin
          r_timer <= r_timer + TMR_ONE;
          // A submit on the final timer cycle takes priority over the timeout.
          if (bus.submit) begin
            if (bus.match) begin
              r_hit   <= 1'b1;
              r_score <= sat_inc(r_score);
            end else begin
              r_miss  <= 1'b1;
            end
          end else if (w_timeout) begin
            r_miss <= 1'b1;
          end
        end
        S_RESULT: r_round <= r_round + ONE;
        default: ;
      endcase
    end
  end

  assign bus.target       = r_target;
  assign bus.round_active = (r_state == S_WAIT);
  assign bus.hit          = r_hit;
  assign bus.miss         = r_miss;
  assign bus.score        = r_score;
  assign bus.game_over    = (r_state == S_DONE);

endmodule

// File: tb/tb_target_generator.sv
// Self-checking bench for target_generator: table-driven game, random
// games against a round-level model, target-bump, reset and timeout cases.
module tb_target_generator;
  import target_generator_pkg::*;

  localparam int         G_ROUNDS = 8;
  localparam logic [7:0] G_SEED   = 8'hA5;
  localparam int         SEQ_LEN  = 8192;

  typedef struct {
    int delay;
    bit m;
    bit e_hit;
    bit e_miss;
    int e_score;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       rst_t_n;
  int         checks;
  int         failures;
  int         cyc;
  int         m_score;
  int         m_round;
  logic [3:0] m_prev;
  logic [7:0] lseq [0:SEQ_LEN-1];
  vec_t       tbl [0:7];

  target_generator_if bus ();
  target_generator_if bus_t ();

  target_generator #(.ROUNDS(G_ROUNDS), .TIMEOUT_CYCLES(1000), .SEED(G_SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  target_generator #(.ROUNDS(3), .TIMEOUT_CYCLES(4), .SEED(8'h3C)) dut_t (
    .clk   (clk),
    .rst_n (rst_t_n),
    .bus   (bus_t)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock edges since the last reset release = LFSR steps taken by the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    logic nb;
    nb = x[7] ^ x[5] ^ x[4] ^ x[3];
    return {x[6:0], nb};
  endfunction

  function automatic logic [3:0] nib(input int k);
    logic [7:0] v;
    v = (k < SEQ_LEN) ? lseq[k] : 8'h00;
    return v[3:0];
  endfunction

  function automatic logic [3:0] predict(input logic [3:0] prev, input logic [3:0] n);
    return (n == prev) ? n + 4'd1 : n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_start();
    int c;
    logic [3:0] exp_t;
    c = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ra_in_load", bus.round_active, 0);
    chk("score_clr", bus.score, 0);
    chk("go_clr", bus.game_over, 0);
    m_round = 0;
    @(negedge clk);
    exp_t  = predict(m_prev, nib(c + 1));
    m_prev = exp_t;
    chk("ra_start", bus.round_active, 1);
    chk("target_start", bus.target, exp_t);
    chk("score_start", bus.score, 0);
  endtask

  task automatic do_round(input int delay, input bit m, input bit noise,
                          input bit e_hit, input bit e_miss, input int e_score);
    int c;
    logic [3:0] exp_t;
    for (int i = 0; i < delay; i++) begin
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("ra_wait", bus.round_active, 1);
    bus.submit = 1'b1;
    bus.match  = m;
    c = cyc;
    @(negedge clk);
    bus.submit = 1'b0;
    bus.match  = 1'b0;
    chk("hit", bus.hit, e_hit);
    chk("miss", bus.miss, e_miss);
    chk("score", bus.score, e_score);
    chk("ra_result", bus.round_active, 0);
    m_round++;
    if (m_round == G_ROUNDS) begin
      @(negedge clk);
      chk("game_over", bus.game_over, 1);
      chk("pulse_len_done", bus.hit | bus.miss, 0);
    end else begin
      if (noise) begin
        bus.submit = 1'($urandom_range(0, 1));
        bus.start  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      chk("pulse_len", bus.hit | bus.miss, 0);
      chk("ra_load", bus.round_active, 0);
      @(negedge clk);
      bus.submit = 1'b0;
      bus.start  = 1'b0;
      exp_t  = predict(m_prev, nib(c + 2));
      m_prev = exp_t;
      chk("ra_next", bus.round_active, 1);
      chk("target_next", bus.target, exp_t);
    end
  endtask

  initial begin
    logic [3:0] want;
    bit found;
    bit m;

    rst_n   = 1'b0;
    rst_t_n = 1'b0;
    bus.start = 1'b0;   bus.submit = 1'b0;   bus.match = 1'b0;
    bus_t.start = 1'b0; bus_t.submit = 1'b0; bus_t.match = 1'b0;
    checks = 0; failures = 0;
    m_prev = 4'd0; m_score = 0; m_round = 0;
    lseq[0] = G_SEED;
    for (int i = 1; i < SEQ_LEN; i++) lseq[i] = lfsr_step(lseq[i-1]);

    tbl[0] = '{3, 1'b1, 1'b1, 1'b0, 1};
    tbl[1] = '{0, 1'b0, 1'b0, 1'b1, 1};
    tbl[2] = '{5, 1'b1, 1'b1, 1'b0, 2};
    tbl[3] = '{1, 1'b1, 1'b1, 1'b0, 3};
    tbl[4] = '{7, 1'b0, 1'b0, 1'b1, 3};
    tbl[5] = '{2, 1'b1, 1'b1, 1'b0, 4};
    tbl[6] = '{0, 1'b1, 1'b1, 1'b0, 5};
    tbl[7] = '{4, 1'b0, 1'b0, 1'b1, 5};

    repeat (3) @(negedge clk);
    chk("rst_target", bus.target, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_ra", bus.round_active, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_miss", bus.miss, 0);
    chk("rst_go", bus.game_over, 0);

    // Game 1: start at cycle 10, fixed table of rounds
    rst_n = 1'b1;
    while (cyc < 10) @(negedge clk);
    do_start();
    for (int i = 0; i < 8; i++)
      do_round(tbl[i].delay, tbl[i].m, 1'b0, tbl[i].e_hit, tbl[i].e_miss, tbl[i].e_score);
    chk("done_target_hold", bus.target, m_prev);
    bus.submit = 1'b1;
    bus.match  = 1'b1;
    @(negedge clk);
    bus.submit = 1'b0;
    bus.match  = 1'b0;
    chk("done_submit_ignored", bus.hit, 0);
    chk("done_score_hold", bus.score, 5);
    chk("done_go_hold", bus.game_over, 1);
    chk("done_target_hold2", bus.target, m_prev);

    // Game 2: all hits, random timing, stray start/submit outside WAIT
    do_start();
    for (int i = 0; i < 8; i++)
      do_round($urandom_range(0, 12), 1'b1, 1'b1, 1'b1, 1'b0, i + 1);
    chk("all_hits_score", bus.score, 8);

    // Game 3: random guesses against the model score
    do_start();
    m_score = 0;
    for (int i = 0; i < 8; i++) begin
      m = 1'($urandom_range(0, 1));
      m_score = (m_score + int'(m) > 15) ? 15 : m_score + int'(m);
      do_round($urandom_range(0, 12), m, 1'b1, m, !m, m_score);
    end

    // Game 4: time submits so the LOAD nibble repeats the previous target
    do_start();
    m_score = 0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++)
      if (nib(cyc + 2) == m_prev) found = 1'b1; else @(negedge clk);
    chk("plan_bump", found, 1);
    want = m_prev + 4'd1;
    m_score++;
    do_round(0, 1'b1, 1'b0, 1'b1, 1'b0, m_score);
    chk("bump_target", bus.target, want);
    if (m_prev == 4'd15) begin
      m_score++;
      do_round(0, 1'b1, 1'b0, 1'b1, 1'b0, m_score);
    end
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++)
      if (predict(m_prev, nib(cyc + 2)) == 4'd15) found = 1'b1; else @(negedge clk);
    chk("plan_fifteen", found, 1);
    m_score++;
    do_round(0, 1'b1, 1'b0, 1'b1, 1'b0, m_score);
    chk("target_fifteen", bus.target, 15);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++)
      if (nib(cyc + 2) == 4'd15) found = 1'b1; else @(negedge clk);
    chk("plan_wrap", found, 1);
    m_score++;
    do_round(0, 1'b1, 1'b0, 1'b1, 1'b0, m_score);
    chk("wrap_target", bus.target, 0);
    chk("pre_rst_score", bus.score, m_score);

    // Asynchronous reset in the middle of WAIT
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ra", bus.round_active, 0);
    chk("arst_score", bus.score, 0);
    chk("arst_target", bus.target, 0);
    chk("arst_hit", bus.hit, 0);
    chk("arst_miss", bus.miss, 0);
    chk("arst_go", bus.game_over, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_pulse", bus.hit | bus.miss, 0);
    end
    rst_n = 1'b1;
    m_prev = 4'd0;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", bus.round_active | bus.game_over, 0);

    // Game 5: restart after reset, then score saturation
    do_start();
    force dut.r_score = 4'd15;
    @(negedge clk);
    release dut.r_score;
    chk("forced_score", bus.score, 15);
    do_round(0, 1'b1, 1'b0, 1'b1, 1'b0, 15);

    // Short-timeout instance: timeout miss and submit-vs-timeout priority
    rst_t_n = 1'b1;
    repeat (2) @(negedge clk);
    bus_t.start = 1'b1;
    @(negedge clk);
    bus_t.start = 1'b0;
    @(negedge clk);
    chk("t_ra_rise", bus_t.round_active, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("t_wait_hold", bus_t.round_active, 1);
      chk("t_no_early_miss", bus_t.miss, 0);
    end
    @(negedge clk);
    chk("t_timeout_miss", bus_t.miss, 1);
    chk("t_timeout_hit", bus_t.hit, 0);
    chk("t_timeout_score", bus_t.score, 0);
    @(negedge clk);
    chk("t_miss_len", bus_t.miss, 0);
    @(negedge clk);
    chk("t_ra2", bus_t.round_active, 1);
    repeat (3) @(negedge clk);
    chk("t_ra2_hold", bus_t.round_active, 1);
    bus_t.submit = 1'b1;
    bus_t.match  = 1'b1;
    @(negedge clk);
    bus_t.submit = 1'b0;
    bus_t.match  = 1'b0;
    chk("t_tie_hit", bus_t.hit, 1);
    chk("t_tie_miss", bus_t.miss, 0);
    chk("t_tie_score", bus_t.score, 1);
    repeat (2) @(negedge clk);
    chk("t_ra3", bus_t.round_active, 1);
    bus_t.submit = 1'b1;
    @(negedge clk);
    bus_t.submit = 1'b0;
    chk("t_wrong_miss", bus_t.miss, 1);
    @(negedge clk);
    chk("t_game_over", bus_t.game_over, 1);
    chk("t_final_score", bus_t.score, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
